// File: rtl/vga_sync_generator.sv
// VGA raster timing: h/v phase counters with registered sync, video and
// coordinate outputs for the downstream pixel logic.

module vga_phase_fsm #(
  parameter int VIS   = 640,
  parameter int FRONT = 16,
  parameter int SYNC  = 96,
  parameter int BACK  = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [9:0] count,
  output logic       in_visible,
  output logic       in_sync,
  output logic       wrap
);

  typedef enum logic [1:0] {
    PH_VISIBLE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  localparam int TOTAL = VIS + FRONT + SYNC + BACK;
  localparam logic [10:0] END_VIS   = 11'(VIS);
  localparam logic [10:0] END_FRONT = 11'(VIS + FRONT);
  localparam logic [10:0] END_SYNC  = 11'(VIS + FRONT + SYNC);
  localparam logic [10:0] LAST      = 11'(TOTAL - 1);

  phase_t     state;
  phase_t     state_n;
  logic [9:0] count_n;

  // First phase of non-zero width at or after p; zero-width phases are skipped.
  function automatic phase_t first_from(phase_t p);
    phase_t r;
    r = PH_VISIBLE;
    unique case (p)
      PH_VISIBLE: begin
        if (VIS != 0)        r = PH_VISIBLE;
        else if (FRONT != 0) r = PH_FRONT;
        else if (SYNC != 0)  r = PH_SYNC;
        else                 r = PH_BACK;
      end
      PH_FRONT: begin
        if (FRONT != 0)      r = PH_FRONT;
        else if (SYNC != 0)  r = PH_SYNC;
        else if (BACK != 0)  r = PH_BACK;
        else                 r = PH_VISIBLE;
      end
      PH_SYNC: begin
        if (SYNC != 0)       r = PH_SYNC;
        else if (BACK != 0)  r = PH_BACK;
        else                 r = PH_VISIBLE;
      end
      PH_BACK: r = PH_BACK;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      state <= first_from(PH_VISIBLE);
    end else begin
      count <= count_n;
      state <= state_n;
    end
  end

  always_comb begin
    wrap    = step && (11'(count) == LAST);
    count_n = count;
    state_n = state;
    if (step) begin
      if (wrap) begin
        count_n = '0;
        state_n = first_from(PH_VISIBLE);
      end else begin
        count_n = count + 10'd1;
        unique case (state)
          PH_VISIBLE:
            if (11'(count_n) == END_VIS)
              state_n = first_from(PH_FRONT);
          PH_FRONT:
            if (11'(count_n) == END_FRONT)
              state_n = first_from(PH_SYNC);
          PH_SYNC:
            if (11'(count_n) == END_SYNC)
              state_n = PH_BACK;
          PH_BACK:
            state_n = PH_BACK;
        endcase
      end
    end
  end

  assign in_visible = (state == PH_VISIBLE);
  assign in_sync    = (state == PH_SYNC);

endmodule

module vga_sync_generator #(
  parameter int   H_VISIBLE  = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_VISIBLE  = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Video_On,
  output logic [9:0] o_X,
  output logic [9:0] o_Y,
  output logic       o_Line_Start,
  output logic       o_Frame_Start,
  output logic [7:0] o_Frame_Count
);

  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       h_vis;
  logic       h_sync;
  logic       h_wrap;
  logic       v_vis;
  logic       v_sync;
  logic       v_wrap;
  logic [7:0] frame_cnt;

  vga_phase_fsm #(
    .VIS   (H_VISIBLE),
    .FRONT (H_FRONT),
    .SYNC  (H_SYNC),
    .BACK  (H_BACK)
  ) h_fsm (
    .clk        (i_Clk),
    .rst        (i_Reset),
    .step       (1'b1),
    .count      (h_count),
    .in_visible (h_vis),
    .in_sync    (h_sync),
    .wrap       (h_wrap)
  );

  vga_phase_fsm #(
    .VIS   (V_VISIBLE),
    .FRONT (V_FRONT),
    .SYNC  (V_SYNC),
    .BACK  (V_BACK)
  ) v_fsm (
    .clk        (i_Clk),
    .rst        (i_Reset),
    .step       (h_wrap),
    .count      (v_count),
    .in_visible (v_vis),
    .in_sync    (v_sync),
    .wrap       (v_wrap)
  );

  // Bumped on the wrap edge so the register shows it alongside Frame_Start.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      frame_cnt <= '0;
    end else if (v_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_HSync       <= ~H_SYNC_POL;
      o_VSync       <= ~V_SYNC_POL;
      o_Video_On    <= 1'b0;
      o_X           <= '0;
      o_Y           <= '0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Frame_Count <= '0;
    end else begin
      o_HSync       <= h_sync ? H_SYNC_POL : ~H_SYNC_POL;
      o_VSync       <= v_sync ? V_SYNC_POL : ~V_SYNC_POL;
      o_Video_On    <= h_vis && v_vis;
      o_X           <= h_count;
      o_Y           <= v_count;
      o_Line_Start  <= (h_count == 10'd0);
      o_Frame_Start <= (h_count == 10'd0) && (v_count == 10'd0);
      o_Frame_Count <= frame_cnt;
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: default timing plus a small override,
// hand-written vectors and a per-cycle arithmetic reference model.

module tb_vga_sync_generator;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  typedef struct {
    int    k;
    bit    sel;
    string name;
    out_t  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       d_hs, d_vs, d_von, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic       s_hs, s_vs, s_von, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;

  int checks = 0;
  int errors = 0;
  int printed = 0;
  int k = -1;
  vec_t tbl[$];

  always #5 clk = ~clk;

  vga_sync_generator dut_d (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .o_HSync       (d_hs),
    .o_VSync       (d_vs),
    .o_Video_On    (d_von),
    .o_X           (d_x),
    .o_Y           (d_y),
    .o_Line_Start  (d_ls),
    .o_Frame_Start (d_fs),
    .o_Frame_Count (d_fc)
  );

  vga_sync_generator #(
    .H_VISIBLE  (8),
    .H_FRONT    (2),
    .H_SYNC     (2),
    .H_BACK     (2),
    .V_VISIBLE  (4),
    .V_FRONT    (1),
    .V_SYNC     (1),
    .V_BACK     (1),
    .H_SYNC_POL (1'b1),
    .V_SYNC_POL (1'b0)
  ) dut_s (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .o_HSync       (s_hs),
    .o_VSync       (s_vs),
    .o_Video_On    (s_von),
    .o_X           (s_x),
    .o_Y           (s_y),
    .o_Line_Start  (s_ls),
    .o_Frame_Start (s_fs),
    .o_Frame_Count (s_fc)
  );

  function automatic out_t mk(int x, int y, bit hs, bit vs, bit von,
                              bit ls, bit fs, int fc);
    out_t o;
    o.hs  = hs;
    o.vs  = vs;
    o.von = von;
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.ls  = ls;
    o.fs  = fs;
    o.fc  = 8'(fc);
    return o;
  endfunction

  // Pixel k since reset release: plain div/mod over the raster.
  function automatic out_t model(int kk, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb,
                                 bit hp, bit vp);
    int ht, vt, x, line, y;
    bit hs, vs;
    if (kk < 0) return mk(0, 0, ~hp, ~vp, 0, 0, 0, 0);
    ht   = hv + hf + hsw + hb;
    vt   = vv + vf + vsw + vb;
    x    = kk % ht;
    line = kk / ht;
    y    = line % vt;
    hs   = (x >= hv + hf && x < hv + hf + hsw) ? hp : ~hp;
    vs   = (y >= vv + vf && y < vv + vf + vsw) ? vp : ~vp;
    return mk(x, y, hs, vs, (x < hv) && (y < vv), x == 0,
              (x == 0) && (y == 0), (line / vt) % 256);
  endfunction

  function automatic out_t d_out();
    return {d_hs, d_vs, d_von, d_x, d_y, d_ls, d_fs, d_fc};
  endfunction

  function automatic out_t s_out();
    return {s_hs, s_vs, s_von, s_x, s_y, s_ls, s_fs, s_fc};
  endfunction

  task automatic chk(string nm, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (printed < 30) begin
        printed++;
        $display("FAIL %s k=%0d got hs%b vs%b von%b x%0d y%0d ls%b fs%b fc%0d want hs%b vs%b von%b x%0d y%0d ls%b fs%b fc%0d",
                 nm, k, act.hs, act.vs, act.von, act.x, act.y, act.ls,
                 act.fs, act.fc, exp.hs, exp.vs, exp.von, exp.x, exp.y,
                 exp.ls, exp.fs, exp.fc);
      end
    end
  endtask

  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    k = r ? -1 : k + 1;
    chk("model_default", d_out(),
        model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
    chk("model_small", s_out(),
        model(k, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b0));
  endtask

  task automatic add(int kk, bit sel, string nm, out_t e);
    vec_t v;
    v.k    = kk;
    v.sel  = sel;
    v.name = nm;
    v.exp  = e;
    tbl.push_back(v);
  endtask

  task automatic run_to(int target);
    int guard;
    guard = 0;
    while (k < target && guard < 40000) begin
      step();
      guard++;
    end
    checks++;
    if (k != target) begin
      errors++;
      $display("FAIL run_to got k=%0d want %0d", k, target);
    end
  endtask

  initial begin
    add(0,     0, "d_origin",   mk(0,   0, 1, 1, 1, 1, 1, 0));
    add(0,     1, "s_origin",   mk(0,   0, 0, 1, 1, 1, 1, 0));
    add(7,     1, "s_last_vis", mk(7,   0, 0, 1, 1, 0, 0, 0));
    add(8,     1, "s_vid_off",  mk(8,   0, 0, 1, 0, 0, 0, 0));
    add(10,    1, "s_hs_on",    mk(10,  0, 1, 1, 0, 0, 0, 0));
    add(11,    1, "s_hs_last",  mk(11,  0, 1, 1, 0, 0, 0, 0));
    add(12,    1, "s_hs_off",   mk(12,  0, 0, 1, 0, 0, 0, 0));
    add(14,    1, "s_line1",    mk(0,   1, 0, 1, 1, 1, 0, 0));
    add(56,    1, "s_vfront",   mk(0,   4, 0, 1, 0, 1, 0, 0));
    add(70,    1, "s_vs_on",    mk(0,   5, 0, 0, 0, 1, 0, 0));
    add(83,    1, "s_vs_last",  mk(13,  5, 0, 0, 0, 0, 0, 0));
    add(84,    1, "s_vs_off",   mk(0,   6, 0, 1, 0, 1, 0, 0));
    add(98,    1, "s_frame1",   mk(0,   0, 0, 1, 1, 1, 1, 1));
    add(639,   0, "d_last_vis", mk(639, 0, 1, 1, 1, 0, 0, 0));
    add(640,   0, "d_vid_off",  mk(640, 0, 1, 1, 0, 0, 0, 0));
    add(655,   0, "d_pre_hs",   mk(655, 0, 1, 1, 0, 0, 0, 0));
    add(656,   0, "d_hs_on",    mk(656, 0, 0, 1, 0, 0, 0, 0));
    add(751,   0, "d_hs_last",  mk(751, 0, 0, 1, 0, 0, 0, 0));
    add(752,   0, "d_hs_off",   mk(752, 0, 1, 1, 0, 0, 0, 0));
    add(799,   0, "d_line_end", mk(799, 0, 1, 1, 0, 0, 0, 0));
    add(800,   0, "d_line1",    mk(0,   1, 1, 1, 1, 1, 0, 0));
    add(1440,  0, "d_l1_off",   mk(640, 1, 1, 1, 0, 0, 0, 0));
    add(24990, 1, "s_frame255", mk(0,   0, 0, 1, 1, 1, 1, 255));
    add(25088, 1, "s_fc_wrap",  mk(0,   0, 0, 1, 1, 1, 1, 0));

    rst = 1'b1;
    repeat (3) step();
    chk("d_reset", d_out(), mk(0, 0, 1, 1, 0, 0, 0, 0));
    chk("s_reset", s_out(), mk(0, 0, 0, 1, 0, 0, 0, 0));
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_to(tbl[i].k);
      if (tbl[i].sel) chk(tbl[i].name, s_out(), tbl[i].exp);
      else            chk(tbl[i].name, d_out(), tbl[i].exp);
    end

    // Reset while small is at (5,3) and default is mid-line.
    run_to(25135);
    chk("s_pre_rst", s_out(), mk(5, 3, 0, 1, 1, 0, 0, 0));
    rst = 1'b1;
    step();
    chk("d_mid_rst", d_out(), mk(0, 0, 1, 1, 0, 0, 0, 0));
    chk("s_mid_rst", s_out(), mk(0, 0, 0, 1, 0, 0, 0, 0));
    rst = 1'b0;
    step();
    chk("d_restart", d_out(), mk(0, 0, 1, 1, 1, 1, 1, 0));
    chk("s_restart", s_out(), mk(0, 0, 0, 1, 1, 1, 1, 0));

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    repeat (300) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
